// File: rtl/pipe_pkg.sv
// Shared widths, state encoding and constants for the elastic pipeline stage buffer.
package pipe_pkg;

    localparam int WB_W   = 2;
    localparam int MEM_W  = 9;
    localparam int FLAG_W = 4;
    localparam int PC_W   = 32;
    localparam int RDST_W = 3;
    localparam int WORD_W = 16;

    localparam int PIPE_CTRL_W = WB_W + MEM_W;
    // pc, Rdst, alu result, read data, flags
    localparam int PIPE_DATA_W = PC_W + RDST_W + WORD_W + WORD_W + FLAG_W;
    localparam int PIPE_CNT_W  = 16;

    // Encoded as {main_valid, skid_valid}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } pipe_state_e;

    localparam logic [PIPE_CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffered pipeline entry: valid + control + payload, updated on the falling edge.
module pipe_entry_reg #(
    parameter int CTRL_W = 11,
    parameter int DATA_W = 71
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // A cleared entry zeroes its control bits (bubble) but keeps the payload.
    always_ff @(negedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            q_data  <= '0;
        end else if (clr) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_ctrl  <= d_ctrl;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_skid_buff.sv
// Elastic two-entry (main + skid) pipeline stage buffer with flush, freeze and stall counter.
module pipe_skid_buff
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              acc;
    logic              take;
    logic              main_load;
    logic              main_clr;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clr;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;
    pipe_state_e       state;

    assign state   = pipe_state_e'({o_valid, skid_valid});
    assign o_full  = o_valid & skid_valid;
    // Registered full only: no combinational i_ready -> o_ready path.
    assign o_ready = ~skid_valid & enable;
    assign acc     = i_valid & o_ready;
    assign take    = o_valid & i_ready & enable;

    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (enable) begin
            case (state)
                EMPTY: begin
                    if (acc) main_load = 1'b1;
                end
                BUSY: begin
                    if (acc && take)  main_load = 1'b1;
                    else if (acc)     skid_load = 1'b1;
                    else if (take)    main_clr  = 1'b1;
                end
                FULL: begin
                    if (take) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : i_ctrl;
    assign main_d_data = main_from_skid ? skid_data : i_data;

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clr     (main_clr),
        .d_ctrl  (main_d_ctrl),
        .d_data  (main_d_data),
        .q_valid (o_valid),
        .q_ctrl  (o_ctrl),
        .q_data  (o_data)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clr     (skid_clr),
        .d_ctrl  (i_ctrl),
        .d_data  (i_data),
        .q_valid (skid_valid),
        .q_ctrl  (skid_ctrl),
        .q_data  (skid_data)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            o_stall_cnt <= '0;
        end else if (!flush && enable && o_valid && !i_ready && (o_stall_cnt != {CNT_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipe_skid_buff.md
Name: pipe_skid_buff

Overview:
- Parametrised, elastic inter-stage pipeline buffer; successor to the fixed-field stage buffers (ALU/MEM and similar).
- Carries a control field (WB+MEM bits) and a data payload (pc, Rdst, ALU result, read data, flags) between two pipeline stages.
- Adds over plain enable/reset buffers: valid/ready handshake, a 2-entry skid so a downstream stall does not combinationally stall upstream, flush with bubble insertion, and a saturating stall-cycle counter.

Parameters:
- CTRL_W, 11, control field width (WB 2 + MEM 9); cleared on bubbles.
- DATA_W, 71, payload width (pc 32 + Rdst 3 + alu 16 + read_data1 16 + flags 4).
- CNT_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  clock; all state updates on falling edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  global freeze. 0 = hold all state; o_ready forced 0; no transfer on either side.
- flush  in  1  kill all buffered entries (branch/exception squash).
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  buffer can accept. Equals !full & enable.
- i_ctrl  in  CTRL_W  upstream control field.
- i_data  in  DATA_W  upstream payload.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts head.
- o_ctrl  out  CTRL_W  head control field; all-zero whenever o_valid=0.
- o_data  out  DATA_W  head payload; don't-care when o_valid=0.
- o_full  out  1  both entries occupied.
- o_stall_cnt  out  CNT_W  saturating count of cycles with o_valid=1 and i_ready=0.

Behaviour:
- Storage:
  - main entry: registered outputs o_valid/o_ctrl/o_data.
  - skid entry: skid_valid/skid_ctrl/skid_data.
- Definitions:
  - acc = i_valid & o_ready.
  - take = o_valid & i_ready & enable.
  - Transfers are evaluated at the falling edge.
- States (encoded from main/skid valid):
  - EMPTY(0,0), BUSY(1,0), FULL(1,1). (0,1) is illegal and never reached.
- Priority at each falling edge: rst > flush > !enable > normal transitions.
- Reset: o_valid=0, skid_valid=0, o_ctrl=0, o_data=0, skid regs=0, o_stall_cnt=0 → state EMPTY.
  - Reset mid-transfer discards both entries.
- Flush:
  - o_valid=0, skid_valid=0, o_ctrl=0; o_data and skid_data held.
  - A concurrent acc is dropped, and counts as no handshake for upstream.
  - A concurrent take is not counted.
  - o_stall_cnt unchanged.
- enable=0: every register holds, including o_stall_cnt.
- Transitions (enable=1, no flush):
  - EMPTY: acc → main<=input, BUSY.
  - BUSY:
    - acc&take → main<=input, stay BUSY.
    - acc&!take → skid<=input, FULL.
    - !acc&take → o_valid=0, o_ctrl=0, EMPTY.
    - else hold.
  - FULL: o_ready=0, so acc is impossible.
    - take → main<=skid, skid_valid=0, BUSY.
    - else hold.
- Timing:
  - Latency: 1 falling edge from acc to o_valid when EMPTY/BUSY with take.
  - Throughput: 1 entry/cycle sustained.
  - o_ready depends only on registered full and enable; no combinational i_ready→o_ready path.
- Ordering: strict FIFO; the skid entry never overtakes main.
- o_stall_cnt:
  - +1 each enabled, non-flush edge with o_valid=1 & i_ready=0.
  - Saturates at 2^CNT_W-1; no wrap.
- Reads of i_ctrl/i_data occur only when acc; otherwise the inputs are ignored.

Decomposition:
- Package pipe_pkg:
  - WB_W=2, MEM_W=9, FLAG_W=4, PC_W=32, RDST_W=3, WORD_W=16.
  - CTRL_W/DATA_W derived constants.
  - State enum {EMPTY, BUSY, FULL} for debug visibility.
  - Zero-bubble constant for the control field.
- Sub-module: pipe_entry_reg, one valid+ctrl+data register with load/clear/hold controls.
  - Instantiated twice: main and skid.
  - Top holds state decode, handshake logic and counter.

Test Plan:
- Reset, then stream 4 entries (pc=0x10,0x11,0x12,0x13) with i_ready=1 → each appears on o_data one edge later, o_valid continuous, o_full=0, o_stall_cnt=0.
- Backpressure: entry A (ctrl=0x7FF), then i_ready=0, send B → o_full=1, o_ready=0. After 3 stalled cycles o_stall_cnt=3. Raise i_ready → A then B, in order.
- Flush while FULL with i_valid=1 (entry C) → next edge o_valid=0, o_ctrl=0, o_full=0, o_ready=1; C never emerges.
- enable=0 for 5 cycles while BUSY with i_ready=1 and i_valid=1 → outputs and o_stall_cnt frozen, o_ready=0, no entry consumed. Re-enable → normal resume.
- Counter saturation with CNT_W=4: hold stall 20 cycles → o_stall_cnt=15 and stays 15.
- rst asserted while FULL and flush=1 simultaneously → all outputs zero next edge, state EMPTY, o_ready=1.
